// File: rtl/wb_xbar_master_arbiter.sv
// Round-robin arbiter that shares one Wishbone crossbar slave port among NUM_MASTERS
// masters; a per-bus-cycle watchdog errors and aborts accesses the slave never answers.
module wb_xbar_master_arbiter #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                                   clk_i,
  input  logic                                   rst_n_i,
  input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_adr_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_sel_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_dat_i,
  output logic [DATA_WIDTH-1:0]                  m_dat_o,
  output logic [NUM_MASTERS-1:0]                 m_ack_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic [NUM_MASTERS-1:0]                 m_stall_o,
  output logic                                   s_cyc_o,
  output logic                                   s_stb_o,
  output logic                                   s_we_o,
  output logic [ADDR_WIDTH-1:0]                  s_adr_o,
  output logic [DATA_WIDTH/8-1:0]                s_sel_o,
  output logic [DATA_WIDTH-1:0]                  s_dat_o,
  input  logic                                   s_ack_i,
  input  logic                                   s_err_i,
  input  logic                                   s_stall_i,
  input  logic [DATA_WIDTH-1:0]                  s_dat_i,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   timeout_o
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned WDOG_W    = 10;
  localparam int unsigned CNT_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  winner;
  logic [CNT_W-1:0]  outstanding;
  logic [WDOG_W-1:0] wdog;
  logic              sel_cyc;
  logic              sel_stb;
  logic              found;
  logic              any_req;
  logic              own_cyc;
  logic              full;
  logic              issue;
  logic              retire;
  logic              wdog_run;
  logic              wdog_fire;
  int unsigned       cand;

  // Owner's request muxed onto the slave port.
  always_comb begin
    sel_cyc = 1'b0;
    sel_stb = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (owner == IDX_W'(k)) begin
        sel_cyc = m_cyc_i[k];
        sel_stb = m_stb_i[k];
        s_we_o  = m_we_i[k];
        s_adr_o = m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        s_sel_o = m_sel_i[k*SEL_WIDTH +: SEL_WIDTH];
        s_dat_o = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A saturated outstanding counter holds off new strobes until an ack retires one.
  assign own_cyc   = (state == ST_OWN) && sel_cyc;
  assign full      = (outstanding == CNT_W'(3));
  assign s_cyc_o   = own_cyc;
  assign s_stb_o   = own_cyc && sel_stb && !full;
  assign issue     = s_stb_o && !s_stall_i;
  assign retire    = own_cyc && (s_ack_i || s_err_i);
  assign wdog_run  = own_cyc && (outstanding != '0) && !retire && !issue;
  assign wdog_fire = wdog_run && (wdog == WDOG_W'(TIMEOUT - 1));
  assign m_dat_o   = s_dat_i;
  assign any_req   = |m_cyc_i;

  // Per-master handshake returns; only the owner ever sees ack/err or a low stall.
  always_comb begin
    m_stall_o = '1;
    m_ack_o   = '0;
    m_err_o   = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (owner == IDX_W'(k)) begin
        if (state == ST_OWN) begin
          m_stall_o[k] = s_stall_i || full;
          m_ack_o[k]   = own_cyc && s_ack_i;
          m_err_o[k]   = own_cyc && s_err_i;
        end else if (state == ST_ABORT) begin
          m_err_o[k]   = timeout_o;
        end
      end
    end
  end

  // Round-robin search starting just after the previous owner.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = 0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = 32'(last_grant) + i;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
        if (!found && (k == cand) && m_cyc_i[k]) begin
          winner = IDX_W'(k);
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      owner       <= '0;
      last_grant  <= IDX_W'(NUM_MASTERS - 1);
      grant_o     <= '0;
      outstanding <= '0;
      wdog        <= '0;
      timeout_o   <= 1'b0;
    end else begin
      timeout_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner <= winner;
            for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
              grant_o[k] <= (winner == IDX_W'(k));
            end
            state <= ST_OWN;
          end
        end
        ST_OWN: begin
          if (!sel_cyc) begin
            last_grant  <= owner;
            grant_o     <= '0;
            outstanding <= '0;
            wdog        <= '0;
            state       <= ST_IDLE;
          end else if (wdog_fire) begin
            timeout_o   <= 1'b1;
            outstanding <= '0;
            wdog        <= '0;
            state       <= ST_ABORT;
          end else begin
            if (issue && !retire) begin
              outstanding <= outstanding + CNT_W'(1);
            end else if (retire && !issue && (outstanding != '0)) begin
              outstanding <= outstanding - CNT_W'(1);
            end
            wdog <= wdog_run ? (wdog + WDOG_W'(1)) : '0;
          end
        end
        ST_ABORT: begin
          last_grant <= owner;
          grant_o    <= '0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_xbar_master_arbiter.sv
// Directed bench for wb_xbar_master_arbiter: a latency-programmable slave model plus a
// scoreboard of expected ack owner/data, checked with immediate assertions.
module tb_wb_xbar_master_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [N-1:0]    m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0] m_adr_i;
  logic [N*SW-1:0] m_sel_i;
  logic [N*DW-1:0] m_dat_i;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_stall_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat_o;
  logic            s_ack_i, s_err_i, s_stall_i;
  logic [DW-1:0]   s_dat_i;
  logic [N-1:0]    grant_o;
  logic            timeout_o;

  typedef struct {
    int            m;
    logic [DW-1:0] d;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc_n = 0;
  exp_t          sb_q[$];
  int            slv_due[$];
  logic [DW-1:0] slv_dat_q[$];
  int            slv_lat = 1;
  bit            slv_on = 1'b0;
  logic [DW-1:0] slv_next = '0;
  int            exp_owner = 0;
  int            outst = 0;
  int            n_acc = 0;
  int            n_ack = 0;
  int            full_seen = 0;
  bit            accepted = 1'b0;

  wb_xbar_master_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle sample: scoreboard acks, record accepted strobes into the slave model.
  task automatic sample();
    exp_t e;
    @(negedge clk_i);
    accepted = 1'b0;
    if (outst == 3) begin
      full_seen++;
      chk("full_stall", {62'd0, s_stb_o, m_stall_o[exp_owner]}, 64'd1);
    end
    if (m_ack_o != '0) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ack", 64'(m_ack_o), 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ack_owner", 64'(m_ack_o), 64'(1 << e.m));
        chk("ack_data", 64'(m_dat_o), 64'(e.d));
        n_ack++;
        outst--;
      end
    end
    if (s_cyc_o && s_stb_o && !s_stall_i) begin
      accepted = 1'b1;
      n_acc++;
      outst++;
      slv_due.push_back(cyc_n + slv_lat);
      slv_dat_q.push_back(slv_next);
      sb_q.push_back('{m: exp_owner, d: slv_next});
      slv_next = slv_next + 1;
    end
  endtask

  // Step to just after the next rising edge and drive this cycle's slave response.
  task automatic advance();
    @(posedge clk_i);
    #1;
    cyc_n++;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    if (slv_on && (slv_due.size() > 0) && (slv_due[0] <= cyc_n)) begin
      void'(slv_due.pop_front());
      s_ack_i = 1'b1;
      s_dat_i = slv_dat_q.pop_front();
    end
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic clear_model();
    sb_q.delete();
    slv_due.delete();
    slv_dat_q.delete();
    outst = 0;
    n_acc = 0;
    n_ack = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 64'(grant_o), 64'd0);
    chk({tag, "_scyc_stb"}, {62'd0, s_cyc_o, s_stb_o}, 64'd0);
    chk({tag, "_ack_err"}, {60'd0, m_ack_o, m_err_o}, 64'd0);
    chk({tag, "_stall"}, 64'(m_stall_o), 64'd3);
    chk({tag, "_timeout"}, 64'(timeout_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_n_i   = 1'b0;
    m_cyc_i   = '0;
    m_stb_i   = '0;
    m_we_i    = '0;
    m_adr_i   = '0;
    m_sel_i   = '0;
    m_dat_i   = '0;
    s_ack_i   = 1'b0;
    s_err_i   = 1'b0;
    s_stall_i = 1'b0;
    s_dat_i   = '0;
    clear_model();
    advance();
    advance();
    sample();
    chk_reset_vals("rst");
    advance();
    rst_n_i = 1'b1;
  endtask

  initial begin
    // Test 1: M0 single write, slave acks two cycles after acceptance.
    do_reset();
    exp_owner = 0; slv_lat = 2; slv_on = 1'b1; slv_next = 32'h0000_1000;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b01;
    m_adr_i = {32'hFFFF_0000, 32'h0000_0010};
    m_sel_i = {4'h3, 4'hF};
    m_dat_i = {32'h1234_5678, 32'hDEAD_BEEF};
    sample();
    chk("t1_idle_grant", 64'(grant_o), 64'd0);
    advance();
    sample();
    chk("t1_grant", 64'(grant_o), 64'd1);
    chk("t1_cyc_stb_we", {61'd0, s_cyc_o, s_stb_o, s_we_o}, 64'd7);
    chk("t1_adr", 64'(s_adr_o), 64'h10);
    chk("t1_sel", 64'(s_sel_o), 64'hF);
    chk("t1_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
    chk("t1_stall", 64'(m_stall_o), 64'd2);
    chk("t1_accept", 64'(accepted), 64'd1);
    advance();
    m_stb_i = 2'b00;
    for (int i = 0; i < 10 && n_ack < 1; i++) tick();
    chk("t1_ack_count", 64'(n_ack), 64'd1);
    m_cyc_i = 2'b00;
    sample();
    chk("t1_cyc_drop", 64'(s_cyc_o), 64'd0);
    chk("t1_no_extra_ack", 64'(m_ack_o), 64'd0);
    advance();
    sample();
    chk("t1_back_idle", 64'(grant_o), 64'd0);
    advance();

    // Test 2: simultaneous requests from reset, then round-robin order.
    do_reset();
    m_cyc_i = 2'b11;
    sample();
    chk("t2_idle", 64'(grant_o), 64'd0);
    advance();
    sample();
    chk("t2_m0_first", 64'(grant_o), 64'd1);
    chk("t2_m0_cyc", 64'(s_cyc_o), 64'd1);
    advance();
    m_cyc_i = 2'b10;
    sample();
    chk("t2_cyc_drop_comb", 64'(s_cyc_o), 64'd0);
    advance();
    sample();
    chk("t2_idle_gap", 64'(grant_o), 64'd0);
    advance();
    sample();
    chk("t2_m1_second", 64'(grant_o), 64'd2);
    chk("t2_m1_stall", 64'(m_stall_o), 64'd1);
    advance();
    m_cyc_i = 2'b00;
    tick();
    m_cyc_i = 2'b11;
    sample();
    chk("t2_idle2", 64'(grant_o), 64'd0);
    advance();
    sample();
    chk("t2_rr_m0", 64'(grant_o), 64'd1);
    advance();
    m_cyc_i = 2'b00;
    tick();
    tick();

    // Test 3: M1 burst of 4 reads, slave latency 3 so the counter saturates.
    clear_model();
    exp_owner = 1; slv_lat = 3; slv_on = 1'b1; slv_next = 32'd1; full_seen = 0;
    m_cyc_i = 2'b10; m_stb_i = 2'b10; m_we_i = 2'b00;
    m_adr_i = {32'h0000_0100, 32'h0};
    for (int i = 0; i < 40 && n_ack < 4; i++) begin
      sample();
      chk("t3_m0_stall", 64'(m_stall_o[0]), 64'd1);
      advance();
      if (accepted) m_adr_i[AW +: AW] = m_adr_i[AW +: AW] + 32'd4;
      if (n_acc >= 4) m_stb_i = 2'b00;
    end
    chk("t3_ack_count", 64'(n_ack), 64'd4);
    chk("t3_acc_count", 64'(n_acc), 64'd4);
    chk("t3_full_seen", 64'(full_seen > 0), 64'd1);
    m_cyc_i = 2'b00;
    tick();
    tick();

    // Test 4: M0 read the slave never answers; watchdog fires after TMO idle cycles.
    clear_model();
    exp_owner = 0; slv_lat = 1; slv_on = 1'b0;
    m_cyc_i = 2'b01; m_stb_i = 2'b01; m_we_i = 2'b00;
    m_adr_i = {32'h0, 32'h0000_0020};
    tick();
    sample();
    chk("t4_accept", 64'(accepted), 64'd1);
    advance();
    m_stb_i = 2'b00;
    for (int k = 1; k <= int'(TMO); k++) begin
      sample();
      chk("t4_no_early_err", {61'd0, m_err_o, timeout_o}, 64'd0);
      chk("t4_cyc_held", 64'(s_cyc_o), 64'd1);
      advance();
    end
    s_ack_i = 1'b1;
    sample();
    chk("t4_err", 64'(m_err_o), 64'd1);
    chk("t4_timeout", 64'(timeout_o), 64'd1);
    chk("t4_abort_cyc", 64'(s_cyc_o), 64'd0);
    chk("t4_late_ack", 64'(m_ack_o), 64'd0);
    chk("t4_abort_stall", 64'(m_stall_o), 64'd3);
    advance();
    m_cyc_i = 2'b00;
    s_ack_i = 1'b1;
    sample();
    chk("t4_after_abort", {58'd0, grant_o, m_ack_o, m_err_o}, 64'd0);
    chk("t4_pulse_once", 64'(timeout_o), 64'd0);
    advance();
    s_ack_i = 1'b0;
    clear_model();

    // Test 5: reset while M1 owns with one access outstanding.
    exp_owner = 1; slv_on = 1'b0;
    m_cyc_i = 2'b10; m_stb_i = 2'b10;
    tick();
    sample();
    chk("t5_accept", 64'(accepted), 64'd1);
    chk("t5_m1_owns", 64'(grant_o), 64'd2);
    advance();
    m_stb_i = 2'b00;
    m_cyc_i = 2'b11;
    rst_n_i = 1'b0;
    tick();
    sample();
    chk_reset_vals("t5_rst");
    advance();
    rst_n_i = 1'b1;
    clear_model();
    sample();
    chk("t5_idle", 64'(grant_o), 64'd0);
    advance();
    sample();
    chk("t5_m0_first", 64'(grant_o), 64'd1);
    advance();
    m_cyc_i = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
